// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
// Double-buffered value/dp registers commit only at the frame boundary, so a frame never tears.
module seg_scan_ctrl #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  output logic [N_DIGITS-1:0]     anode_n,
  output logic                    dp_n,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int IDX_W   = $clog2(N_DIGITS);
  localparam int MAX_CNT = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int TICK_W  = $clog2(MAX_CNT);

  localparam logic [TICK_W-1:0]   GAP_LAST = TICK_W'(GAP_CYCLES - 1);
  localparam logic [TICK_W-1:0]   ON_LAST  = TICK_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ALL_DARK = {N_DIGITS{1'b1}};
  localparam logic [N_DIGITS-1:0] ONE_HOT0 = {{(N_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_GAP = 2'd1,
    ST_ON  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [IDX_W-1:0]        digit_idx;
  logic [IDX_W-1:0]        next_idx;
  logic [TICK_W-1:0]       tick_cnt;
  logic [TICK_W-1:0]       next_tick;
  logic                    commit;

  logic [4*N_DIGITS-1:0]   shadow_value;
  logic [N_DIGITS-1:0]     shadow_dp;
  logic [4*N_DIGITS-1:0]   active_value;
  logic [N_DIGITS-1:0]     active_dp;
  logic [4*N_DIGITS-1:0]   next_shadow_value;
  logic [N_DIGITS-1:0]     next_shadow_dp;
  logic [4*N_DIGITS-1:0]   next_active_value;
  logic [N_DIGITS-1:0]     next_active_dp;
  logic                    next_pending;

  logic [N_DIGITS-1:0]     blank_mask;
  logic [3:0]              next_bcd;
  logic [N_DIGITS-1:0]     next_anode_n;
  logic                    next_dp_n;
  logic                    next_frame_done;

  // Digit i>0 is a leading zero when it and every more-significant nibble are zero.
  function automatic logic [N_DIGITS-1:0] lz_mask(input logic [4*N_DIGITS-1:0] v);
    logic [N_DIGITS-1:0] mask;
    logic                zero_above;
    mask       = {N_DIGITS{1'b0}};
    zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (v[4*i +: 4] == 4'h0);
      mask[i]    = zero_above;
    end
    return mask;
  endfunction

  // Scan state, digit index and slot tick counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      digit_idx <= {IDX_W{1'b0}};
      tick_cnt  <= {TICK_W{1'b0}};
    end else begin
      state     <= next_state;
      digit_idx <= next_idx;
      tick_cnt  <= next_tick;
    end
  end

  // Next-state logic; commit marks entry into digit 0's GAP, the frame boundary.
  always_comb begin
    next_state = state;
    next_idx   = digit_idx;
    next_tick  = tick_cnt;
    commit     = 1'b0;
    if (!enable) begin
      next_state = ST_OFF;
      next_idx   = {IDX_W{1'b0}};
      next_tick  = {TICK_W{1'b0}};
    end else begin
      case (state)
        ST_OFF: begin
          next_state = ST_GAP;
          next_idx   = {IDX_W{1'b0}};
          next_tick  = {TICK_W{1'b0}};
          commit     = 1'b1;
        end
        ST_GAP: begin
          if (tick_cnt == GAP_LAST) begin
            next_state = ST_ON;
            next_tick  = {TICK_W{1'b0}};
          end else begin
            next_tick = tick_cnt + 1'b1;
          end
        end
        ST_ON: begin
          if (tick_cnt == ON_LAST) begin
            next_state = ST_GAP;
            next_tick  = {TICK_W{1'b0}};
            if (digit_idx == IDX_LAST) begin
              next_idx = {IDX_W{1'b0}};
              commit   = 1'b1;
            end else begin
              next_idx = digit_idx + 1'b1;
            end
          end else begin
            next_tick = tick_cnt + 1'b1;
          end
        end
        default: begin
          next_state = ST_OFF;
          next_idx   = {IDX_W{1'b0}};
          next_tick  = {TICK_W{1'b0}};
        end
      endcase
    end
  end

  // Shadow/active register update; a load coinciding with commit bypasses the shadow.
  always_comb begin
    next_shadow_value = shadow_value;
    next_shadow_dp    = shadow_dp;
    next_active_value = active_value;
    next_active_dp    = active_dp;
    next_pending      = pending;
    if (load) begin
      next_shadow_value = value_in;
      next_shadow_dp    = dp_in;
    end else begin
      next_shadow_value = shadow_value;
      next_shadow_dp    = shadow_dp;
    end
    if (commit) begin
      next_active_value = load ? value_in : shadow_value;
      next_active_dp    = load ? dp_in : shadow_dp;
      next_pending      = 1'b0;
    end else if (load) begin
      next_pending = 1'b1;
    end else begin
      next_pending = pending;
    end
  end

  // Output decode from the upcoming state so every output is registered yet cycle-aligned.
  always_comb begin
    next_bcd        = bcd_out;
    next_anode_n    = ALL_DARK;
    next_dp_n       = 1'b1;
    next_frame_done = 1'b0;
    if (blank_lz) begin
      blank_mask = lz_mask(next_active_value);
    end else begin
      blank_mask = {N_DIGITS{1'b0}};
    end
    case (next_state)
      ST_OFF: begin
        next_bcd = bcd_out;
      end
      ST_GAP: begin
        next_bcd = next_active_value[{next_idx, 2'b00} +: 4];
      end
      ST_ON: begin
        if (blank_mask[next_idx]) begin
          next_anode_n = ALL_DARK;
        end else begin
          next_anode_n = ~(ONE_HOT0 << next_idx);
        end
        next_dp_n       = ~next_active_dp[next_idx];
        next_frame_done = (next_tick == ON_LAST) && (next_idx == IDX_LAST);
      end
      default: begin
        next_bcd = bcd_out;
      end
    endcase
  end

  // Register banks and display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value <= {(4*N_DIGITS){1'b0}};
      shadow_dp    <= {N_DIGITS{1'b0}};
      active_value <= {(4*N_DIGITS){1'b0}};
      active_dp    <= {N_DIGITS{1'b0}};
      pending      <= 1'b0;
      bcd_out      <= 4'h0;
      anode_n      <= ALL_DARK;
      dp_n         <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      shadow_value <= next_shadow_value;
      shadow_dp    <= next_shadow_dp;
      active_value <= next_active_value;
      active_dp    <= next_active_dp;
      pending      <= next_pending;
      bcd_out      <= next_bcd;
      anode_n      <= next_anode_n;
      dp_n         <= next_dp_n;
      frame_done   <= next_frame_done;
    end
  end

endmodule
